// File: rtl/wb_pkg.sv
// Shared widths, encodings and the writeback holding-register type.
// No logic; imported by the writeback block, its interface and the bench.
// Not applicable: package carries no handshake.
package wb_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_IDX_W  = 5;
  localparam int DEST_SRC_W = 2;
  localparam int MEM_OP_W   = 4;

  // Where the register-file write data comes from
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2;

  // Memory operations; only the load flavours matter in writeback
  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd5;

  // Instruction held in the writeback stage
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W-1:0]     pc;
    logic [REG_IDX_W-1:0]  dest_reg;
    logic [DEST_SRC_W-1:0] dest_src;
    logic [WORD_W-1:0]     alu_eval;
    logic [MEM_OP_W-1:0]   mem_op;
  } wb_hold_t;

endpackage

// File: rtl/wb_if.sv
// ME-to-WB instruction bus plus the register-file write port and stall return.
// Wires only; timing is set by the producer and consumer.
// o_stall from the slave side holds the master's instruction in place.
interface wb_if #(
  parameter int CNT_W = 32
);
  import wb_pkg::*;

  logic                  i_valid;
  logic [ADDR_W-1:0]     i_pc;
  logic [REG_IDX_W-1:0]  i_dest_reg;
  logic [DEST_SRC_W-1:0] i_dest_src;
  logic [WORD_W-1:0]     i_alu_eval;
  logic [MEM_OP_W-1:0]   i_mem_op;
  logic                  i_mem_rvalid;
  logic [WORD_W-1:0]     i_mem_rdata;
  logic                  o_dest_en;
  logic [REG_IDX_W-1:0]  o_dest_reg;
  logic [WORD_W-1:0]     o_dest_data;
  logic                  o_stall;
  logic [ADDR_W-1:0]     o_pc;
  logic [CNT_W-1:0]      o_retired;
  logic                  o_rsp_err;

  // Upstream pipeline / memory side
  modport master (
    output i_valid, i_pc, i_dest_reg, i_dest_src, i_alu_eval, i_mem_op,
    output i_mem_rvalid, i_mem_rdata,
    input  o_dest_en, o_dest_reg, o_dest_data, o_stall, o_pc, o_retired, o_rsp_err
  );

  // Writeback stage side
  modport slave (
    input  i_valid, i_pc, i_dest_reg, i_dest_src, i_alu_eval, i_mem_op,
    input  i_mem_rvalid, i_mem_rdata,
    output o_dest_en, o_dest_reg, o_dest_data, o_stall, o_pc, o_retired, o_rsp_err
  );

endinterface

// File: rtl/wb_load_align.sv
// Selects the addressed byte/halfword of a raw memory word and sign/zero-extends it.
// Purely combinational, zero latency.
// No flow control.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [1:0]          byte_off,
  input  logic [WORD_W-1:0]   raw,
  output logic [WORD_W-1:0]   data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the lane by address, then extend according to the load flavour;
  // misaligned halfword/word loads simply use the truncated address.
  always_comb begin
    sel_byte = raw[8*byte_off +: 8];
    sel_half = byte_off[1] ? raw[31:16] : raw[15:0];
    case (mem_op)
      MEM_OP_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      MEM_OP_LBU: data = {24'd0, sel_byte};
      MEM_OP_LH:  data = {{16{sel_half[15]}}, sel_half};
      MEM_OP_LHU: data = {16'd0, sel_half};
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/wb.sv
// Writeback stage: holds the ME result, waits for load data, drives the register-file write port.
// ALU results write one cycle after capture; loads complete in the cycle the memory response arrives.
// o_stall is raised combinationally while a held load has no response yet; capture is frozen meanwhile.
module wb
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic aresetn,
  wb_if.slave  bus
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

  wb_hold_t          hold;
  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              stall;
  logic              completing;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  retired;
  logic              rsp_err;

  // A held load without its response blocks both capture and completion
  assign stall      = (state == ST_LOAD_WAIT) && !bus.i_mem_rvalid;
  assign completing = hold.valid && !stall;

  // Next state follows whatever gets captured; a stall keeps the load pending
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      state_nxt = (bus.i_valid && bus.i_dest_src == DEST_SRC_MEM) ? ST_LOAD_WAIT : ST_RUN;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Holding register captures the ME stage whenever not stalled
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hold <= '0;
    end else if (!stall) begin
      hold.valid    <= bus.i_valid;
      hold.pc       <= bus.i_pc;
      hold.dest_reg <= bus.i_dest_reg;
      hold.dest_src <= bus.i_dest_src;
      hold.alu_eval <= bus.i_alu_eval;
      hold.mem_op   <= bus.i_mem_op;
    end
  end

  // Retired count and sticky stray-response flag
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      retired <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (completing) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.i_mem_rvalid && state == ST_RUN) rsp_err <= 1'b1;
    end
  end

  wb_load_align u_align (
    .mem_op   (hold.mem_op),
    .byte_off (hold.alu_eval[1:0]),
    .raw      (bus.i_mem_rdata),
    .data     (load_word)
  );

  // Register-file write port; x0 writes are dropped
  always_comb begin
    bus.o_dest_en = completing && hold.dest_src != DEST_SRC_NONE && hold.dest_reg != '0;
    case (hold.dest_src)
      DEST_SRC_ALU: bus.o_dest_data = hold.alu_eval;
      DEST_SRC_MEM: bus.o_dest_data = load_word;
      default:      bus.o_dest_data = '0;
    endcase
  end

  assign bus.o_dest_reg = hold.dest_reg;
  assign bus.o_pc       = hold.pc;
  assign bus.o_stall    = stall;
  assign bus.o_retired  = retired;
  assign bus.o_rsp_err  = rsp_err;

endmodule

// File: tb/tb_wb.sv
// Directed and randomized bench for the writeback stage against a behavioural model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
// Load responses are returned after a chosen number of stall cycles.
module tb_wb;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  wb_if #(.CNT_W(32)) bus ();

  wb #(.CNT_W(32)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected load result computed from address arithmetic on the raw word
  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    int sh;
    case (op)
      MEM_OP_LH, MEM_OP_LHU: begin
        sh = ((addr % 4) / 2) * 16;
        v  = (word >> sh) & 32'hFFFF;
        if (op == MEM_OP_LH && v >= 32'h8000) v = v - 32'h10000;
        return v;
      end
      MEM_OP_LB, MEM_OP_LBU: begin
        sh = (addr % 4) * 8;
        v  = (word >> sh) & 32'hFF;
        if (op == MEM_OP_LB && v >= 32'h80) v = v - 32'h100;
        return v;
      end
      default: return word;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.i_valid    = 1'b0;
    bus.i_pc       = '0;
    bus.i_dest_reg = '0;
    bus.i_dest_src = DEST_SRC_NONE;
    bus.i_alu_eval = '0;
    bus.i_mem_op   = MEM_OP_NONE;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                       input logic [3:0] op, input logic [31:0] pc);
    bus.i_valid    = 1'b1;
    bus.i_pc       = pc;
    bus.i_dest_reg = rd;
    bus.i_dest_src = src;
    bus.i_alu_eval = alu;
    bus.i_mem_op   = op;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"},      32'(bus.o_dest_en),   32'd0);
    check({tag, "_reg"},     32'(bus.o_dest_reg),  32'd0);
    check({tag, "_data"},    bus.o_dest_data,      32'd0);
    check({tag, "_stall"},   32'(bus.o_stall),     32'd0);
    check({tag, "_pc"},      bus.o_pc,             32'd0);
    check({tag, "_retired"}, bus.o_retired,        32'd0);
    check({tag, "_rsperr"},  32'(bus.o_rsp_err),   32'd0);
  endtask

  // Issue one load, hold the response back lat cycles, then check the write
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [3:0] op, input logic [31:0] rdata, input int lat,
                         input logic [31:0] exp);
    issue(rd, DEST_SRC_MEM, addr, op, 32'h300);
    tick();
    idle();
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_stall_wait"}, 32'(bus.o_stall),   32'd1);
      check({tag, "_en_wait"},    32'(bus.o_dest_en), 32'd0);
      tick();
    end
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = rdata;
    @(negedge clk);
    check({tag, "_stall_rsp"}, 32'(bus.o_stall),    32'd0);
    check({tag, "_en"},        32'(bus.o_dest_en),  32'd1);
    check({tag, "_reg"},       32'(bus.o_dest_reg), 32'(rd));
    check({tag, "_data"},      bus.o_dest_data,     exp);
    tick();
    bus.i_mem_rvalid = 1'b0;
  endtask

  logic [3:0]  ops [5] = '{MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};

  // Model of the instruction held in writeback during random traffic
  logic        m_valid;
  logic [1:0]  m_src;
  logic [4:0]  m_reg;
  logic [31:0] m_alu;
  logic [3:0]  m_op;
  logic [31:0] m_pc;
  int          m_lat;
  int          m_ret;
  logic        e_stall, e_comp, e_en;

  initial begin
    aresetn = 1'b0;
    idle();
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    #1 aresetn = 1'b1;
    tick();

    // ALU write to x5
    issue(5'd5, DEST_SRC_ALU, 32'h1234_5678, MEM_OP_NONE, 32'h100);
    tick();
    idle();
    @(negedge clk);
    check("alu_en",      32'(bus.o_dest_en),  32'd1);
    check("alu_reg",     32'(bus.o_dest_reg), 32'd5);
    check("alu_data",    bus.o_dest_data,     32'h1234_5678);
    check("alu_pc",      bus.o_pc,            32'h100);
    check("alu_ret_pre", bus.o_retired,       32'd0);
    tick();
    @(negedge clk);
    check("alu_ret_post", bus.o_retired,       32'd1);
    check("alu_en_after", 32'(bus.o_dest_en),  32'd0);

    // Write to x0 is suppressed but still retires
    issue(5'd0, DEST_SRC_ALU, 32'hDEAD_BEEF, MEM_OP_NONE, 32'h104);
    tick();
    idle();
    @(negedge clk);
    check("x0_en", 32'(bus.o_dest_en), 32'd0);
    tick();
    @(negedge clk);
    check("x0_ret", bus.o_retired, 32'd2);

    // Load alignment and extension with varied response latency
    do_load("lb",  5'd7, 32'h1003, MEM_OP_LB,  32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("lbu", 5'd7, 32'h1003, MEM_OP_LBU, 32'h80FF_0000, 3, 32'h0000_0080);
    do_load("lh",  5'd8, 32'h1002, MEM_OP_LH,  32'h8001_7FFF, 0, 32'hFFFF_8001);
    do_load("lhu", 5'd8, 32'h1002, MEM_OP_LHU, 32'h8001_7FFF, 1, 32'h0000_8001);
    do_load("lw",  5'd9, 32'h1000, MEM_OP_LW,  32'h8001_7FFF, 2, 32'h8001_7FFF);
    @(negedge clk);
    check("load_ret", bus.o_retired, 32'd7);
    tick();

    // Back-to-back loads with immediate responses
    issue(5'd10, DEST_SRC_MEM, 32'h2001, MEM_OP_LBU, 32'h200);
    tick();
    issue(5'd11, DEST_SRC_MEM, 32'h2002, MEM_OP_LH, 32'h204);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h1122_A344;
    @(negedge clk);
    check("b2b1_stall", 32'(bus.o_stall),    32'd0);
    check("b2b1_en",    32'(bus.o_dest_en),  32'd1);
    check("b2b1_reg",   32'(bus.o_dest_reg), 32'd10);
    check("b2b1_data",  bus.o_dest_data,     32'h0000_00A3);
    tick();
    idle();
    bus.i_mem_rdata = 32'hC0DE_0042;
    @(negedge clk);
    check("b2b2_stall", 32'(bus.o_stall),    32'd0);
    check("b2b2_en",    32'(bus.o_dest_en),  32'd1);
    check("b2b2_reg",   32'(bus.o_dest_reg), 32'd11);
    check("b2b2_pc",    bus.o_pc,            32'h204);
    check("b2b2_data",  bus.o_dest_data,     32'hFFFF_C0DE);
    tick();
    bus.i_mem_rvalid = 1'b0;
    @(negedge clk);
    check("b2b_ret",   bus.o_retired,       32'd9);
    check("rsperr_lo", 32'(bus.o_rsp_err),  32'd0);
    tick();

    // Stray response while idle sets the sticky error
    bus.i_mem_rvalid = 1'b1;
    tick();
    bus.i_mem_rvalid = 1'b0;
    @(negedge clk);
    check("rsperr_set", 32'(bus.o_rsp_err), 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("rsperr_hold", 32'(bus.o_rsp_err), 32'd1);

    // Random traffic from a fresh reset against the model
    #1 aresetn = 1'b0;
    #2 aresetn = 1'b1;
    idle();
    tick();
    m_valid = 1'b0; m_src = '0; m_reg = '0; m_alu = '0; m_op = '0; m_pc = '0;
    m_lat = 0; m_ret = 0;
    for (int c = 0; c < 300; c++) begin
      bus.i_mem_rvalid = m_valid && m_src == DEST_SRC_MEM && m_lat == 0;
      bus.i_mem_rdata  = $urandom;
      bus.i_valid      = ($urandom_range(0, 3) != 0);
      bus.i_dest_src   = 2'($urandom_range(0, 2));
      bus.i_dest_reg   = 5'($urandom);
      bus.i_alu_eval   = $urandom;
      bus.i_mem_op     = ops[$urandom_range(0, 4)];
      bus.i_pc         = $urandom;
      @(negedge clk);
      e_stall = m_valid && m_src == DEST_SRC_MEM && m_lat != 0;
      e_comp  = m_valid && !e_stall;
      e_en    = e_comp && m_src != DEST_SRC_NONE && m_reg != 0;
      check("rnd_stall",   32'(bus.o_stall),   32'(e_stall));
      check("rnd_en",      32'(bus.o_dest_en), 32'(e_en));
      check("rnd_pc",      bus.o_pc,           m_pc);
      check("rnd_retired", bus.o_retired,      32'(m_ret));
      if (e_en) begin
        check("rnd_reg", 32'(bus.o_dest_reg), 32'(m_reg));
        check("rnd_data", bus.o_dest_data,
              (m_src == DEST_SRC_ALU) ? m_alu : ref_load(m_op, m_alu, bus.i_mem_rdata));
      end
      if (e_comp) m_ret++;
      if (!e_stall) begin
        m_valid = bus.i_valid;
        m_src   = bus.i_dest_src;
        m_reg   = bus.i_dest_reg;
        m_alu   = bus.i_alu_eval;
        m_op    = bus.i_mem_op;
        m_pc    = bus.i_pc;
        m_lat   = $urandom_range(0, 3);
      end else begin
        m_lat--;
      end
      tick();
    end
    bus.i_mem_rvalid = 1'b0;
    idle();
    // Drain any load still pending from the random phase
    for (int c = 0; c < 8 && bus.o_stall; c++) begin
      bus.i_mem_rvalid = 1'b1;
      tick();
      bus.i_mem_rvalid = 1'b0;
    end
    tick();

    // Reset in the middle of a load wait discards the load
    issue(5'd12, DEST_SRC_MEM, 32'h3000, MEM_OP_LW, 32'h400);
    tick();
    idle();
    @(negedge clk);
    check("rstwait_stall", 32'(bus.o_stall), 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check_zero("rstwait");
    tick();
    aresetn = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    check("rstwait_late_en", 32'(bus.o_dest_en), 32'd0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    @(negedge clk);
    check("rstwait_rsperr", 32'(bus.o_rsp_err), 32'd1);
    check("rstwait_ret",    bus.o_retired,      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
